bcd_serial_adder: RTL
=====================

# bcd_serial_adder

Digit-serial multi-digit BCD adder sequencer. It accepts two packed BCD operands of DIGITS digits and walks them LSD-first, one digit per clock, through a single instance of the team's single-digit `bcd_adder` cell. A registered carry links each digit to the next. It sits directly upstream of the `bcd_adder` cell: it feeds the cell's x/y/cin and consumes its sum/cout, turning the combinational digit adder into a handshaked N-digit arithmetic unit.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.
- clk  input  1: sole clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request; sampled only while idle.
- a  input  4*DIGITS: operand A, packed BCD; digit i is at a[4i+3:4i]; digit 0 is least significant.
- b  input  4*DIGITS: operand B, same packing as a.
- cin  input  1: carry into digit 0.
- busy  output  1: high while an operation is in progress.
- done  output  1: one-cycle completion pulse.
- sum  output  4*DIGITS: packed BCD result; held until the next completion.
- cout  output  1: decimal carry out of the most significant digit; held with sum.
- err  output  1: invalid-digit flag; held with sum. Only active when BCD_CHECK_EN is defined.

## Operation
- Two states:
  - IDLE:
    - start=1 latches a, b and cin into internal operand registers.
    - Clears the digit index idx to 0.
    - Moves to RUN.
  - RUN:
    - Each cycle, digit idx of the latched operands plus the carry register drive the `bcd_adder` cell.
    - The cell's sum digit is written into working-result digit idx, and the carry register takes the cell's cout.
    - idx increments.
    - When idx==DIGITS-1, the FSM returns to IDLE instead.
- Completion, at the edge that processes the last digit:
  - sum loads the full working result, including the final digit written at that edge.
  - cout loads the final carry.
  - done is set for exactly one cycle.
- Arithmetic:
  - Each digit result is whatever the `bcd_adder` cell produces. This is exact decimal addition for valid digits (0..9) with cin in {0,1}.
  - The result is a DIGITS-digit decimal value mod 10^DIGITS, with cout as the overflow.
- start while busy=1 is ignored; it is neither queued nor errored.
- a, b and cin may change freely after the accepting edge without affecting the operation.
- Reset mid-operation:
  - The operation aborts and the FSM returns to IDLE.
  - No done pulse is produced.
  - sum, cout and err are cleared to 0.
- Reset values: busy=0, done=0, sum=0, cout=0, err=0. Internal idx, carry and working result are 0.

## Timing
- The accepting edge is E0, where start=1 is sampled in IDLE.
- Digit k is processed at edge E(k+1).
- The final digit is processed at E(DIGITS), and sum, cout and done update at that same edge.
- done is high in the cycle following E(DIGITS), DIGITS cycles after E0.
- busy is high from after E0 through the cycle ending at E(DIGITS). It is low in the done cycle.
- Back-to-back operation: start=1 in the done cycle is accepted, because the FSM is IDLE. Throughput is one result per DIGITS cycles.
- With DIGITS=1, done follows the cycle after E0, i.e. busy is high for one cycle.
- rst has priority over start on the same edge.

## Configuration
- BCD_CHECK_EN defined:
  - At acceptance, every digit of a and b is checked for >9. The result is held in a flag register.
  - err loads this flag at completion, alongside sum and cout.
  - sum is still produced by the cell and is unspecified for invalid digits.
- BCD_CHECK_EN undefined:
  - err is tied to 0.
  - No checking logic is generated.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse -> busy for 4 cycles, then done=1 for one cycle with sum=0x6912, cout=0.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; result held stable after done until the next completion.
- a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1. Immediately re-start in the done cycle with a=0x0005, b=0x0004 -> second done exactly 4 cycles later with sum=0x0009, cout=0.
- start held high continuously during RUN with changing a/b -> only the first operands are used; exactly one done per 4-cycle window.
- rst=1 asserted on the 2nd RUN cycle -> busy=0 next cycle; no done; sum=0, cout=0; a new start then completes normally.
- With BCD_CHECK_EN: a=0x00A0, b=0x0001 -> err=1 at done. a=0x0090, b=0x0001 -> err=0, sum=0x0091.

Source files
------------

// File: rtl/bcd_serial_if.sv
// Handshake/data bundle between a requester and the digit-serial BCD adder.
// DIGITS sets the packed operand/result width (4 bits per BCD digit).
interface bcd_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: walks packed operands LSD-first through one
// bcd_adder cell. Optional macro BCD_CHECK_EN adds invalid-digit flagging (err).
module bcd_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    adj  = raw + 5'd6;
    cout = (raw > 5'd9);
    sum  = cout ? adj[3:0] : raw[3:0];
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  bcd_serial_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     wres;
  logic [W-1:0]     nxt_wres;
  logic [W-1:0]     sum_r;
  logic             cout_r;
  logic             done_r;

  logic [3:0]       dig_a;
  logic [3:0]       dig_b;
  logic [3:0]       cell_sum;
  logic             cell_cout;
  logic             accept;
  logic             last;

  assign accept = (state == S_IDLE) && bus.start;
  assign last   = (state == S_RUN) && (idx == LAST_IDX);

  // Digit select from the latched operands and write-back into the working result
  always_comb begin
    dig_a    = 4'd0;
    dig_b    = 4'd0;
    nxt_wres = wres;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        dig_a              = opa[4*i +: 4];
        dig_b              = opb[4*i +: 4];
        nxt_wres[4*i +: 4] = cell_sum;
      end
    end
  end

  bcd_adder u_cell (
    .x    (dig_a),
    .y    (dig_b),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Operand capture: pure data, only meaningful after an accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= bus.a;
      opb <= bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      wres   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx   <= '0;
            carry <= bus.cin;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          wres  <= nxt_wres;
          carry <= cell_cout;
          if (idx == LAST_IDX) begin
            sum_r  <= nxt_wres;
            cout_r <= cell_cout;
            done_r <= 1'b1;
            state  <= S_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic chk_r;
  logic err_r;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Flag is computed on the raw inputs at acceptance and published at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (accept) chk_r <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
      if (last)   err_r <= chk_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy = (state == S_RUN);
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule
